// File: rtl/ascii_uart_pkg.sv
// Shared definitions for the ASCII UART sender.
//   txState_t  : serializer state encoding (IDLE, START, DATA, STOP)
//   ASCII_CR/LF: line terminator bytes appended when TX_CRLF_EN is defined
//   clksPerBit : integer clock cycles per UART bit
package ascii_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/ascii_uart_sender_if.sv
// Handshake/data bundle between the ASCII producer and the UART sender.
//   ifStart  : request pulse from producer
//   asciiNum : three ASCII bytes, [23:16] sent first
//   txd      : UART serial line, idle high
//   ifBusy   : frame in progress
//   ifDone   : one-cycle completion pulse
// Modports: master = producer side, slave = sender side.
interface ascii_uart_sender_if;
  logic        ifStart;
  logic [23:0] asciiNum;
  logic        txd;
  logic        ifBusy;
  logic        ifDone;

  modport master (output ifStart, asciiNum, input txd, ifBusy, ifDone);
  modport slave  (input ifStart, asciiNum, output txd, ifBusy, ifDone);
endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer, LSB first.
//   clk, rstN : clock and async active-low reset
//   txByte    : byte to send, captured when txValid && txReady
//   txValid   : request to send txByte at this edge
//   txReady   : byte accepted at this edge if txValid (idle, or last cycle of stop bit)
//   txd       : serial output, idle high
// Accepting in the last stop-bit cycle lets bytes go out back to back with no idle gap.
module uart_tx_byte
  import ascii_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] txByte,
  input  logic       txValid,
  output logic       txReady,
  output logic       txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  txState_t         state, stateNext;
  logic [CNT_W-1:0] baudCnt, baudCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shReg, shRegNext;
  logic             txdNext;
  logic             lastCnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      shReg   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= stateNext;
      baudCnt <= baudCntNext;
      bitIdx  <= bitIdxNext;
      shReg   <= shRegNext;
      txd     <= txdNext;
    end
  end

  always_comb begin
    stateNext   = state;
    baudCntNext = baudCnt;
    bitIdxNext  = bitIdx;
    shRegNext   = shReg;
    txdNext     = txd;
    txReady     = 1'b0;
    lastCnt     = (baudCnt == CNT_LAST);

    unique case (state)
      IDLE: begin
        txReady = 1'b1;
        if (txValid) begin
          shRegNext   = txByte;
          txdNext     = 1'b0;
          baudCntNext = '0;
          stateNext   = START;
        end
      end
      START: begin
        if (lastCnt) begin
          baudCntNext = '0;
          bitIdxNext  = '0;
          txdNext     = shReg[0];
          stateNext   = DATA;
        end else begin
          baudCntNext = baudCnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (lastCnt) begin
          baudCntNext = '0;
          if (bitIdx == 3'd7) begin
            txdNext   = 1'b1;
            stateNext = STOP;
          end else begin
            // shift so the next bit to send is always shReg[0]
            bitIdxNext = bitIdx + 3'd1;
            shRegNext  = {1'b0, shReg[7:1]};
            txdNext    = shReg[1];
          end
        end else begin
          baudCntNext = baudCnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (lastCnt) begin
          txReady     = 1'b1;
          baudCntNext = '0;
          if (txValid) begin
            shRegNext = txByte;
            txdNext   = 1'b0;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          baudCntNext = baudCnt + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: rtl/ascii_uart_sender.sv
// Sends a 3-digit ASCII word over UART 8N1, hundreds digit first.
//   clk, rstN : clock and async active-low reset
//   bus       : ascii_uart_sender_if.slave (ifStart, asciiNum in; txd, ifBusy, ifDone out)
// Parameters CLK_FREQ (Hz) and BAUD (bit/s); CLKS_PER_BIT = CLK_FREQ/BAUD must be >= 2.
// Build option TX_CRLF_EN: append CR, LF after the digits (5 bytes per frame).
module ascii_uart_sender
  import ascii_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input logic               clk,
  input logic               rstN,
  ascii_uart_sender_if.slave bus
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);

  generate
    if (CLKS_PER_BIT < 2) begin : gBadBaud
      $error("ascii_uart_sender: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

`ifdef TX_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd2;
`endif

  logic        busyR, doneR;
  logic [2:0]  byteIdx, nextIdx;
  logic [23:0] wordBuf;
  logic [7:0]  nextByte, txByte;
  logic        txValid, txReady;
  logic        accept, lastByte;

  assign accept   = bus.ifStart && !busyR;
  assign lastByte = (byteIdx == LAST_IDX);
  assign nextIdx  = byteIdx + 3'd1;

  always_comb begin
    unique case (nextIdx)
      3'd1:    nextByte = wordBuf[15:8];
      3'd2:    nextByte = wordBuf[7:0];
`ifdef TX_CRLF_EN
      3'd3:    nextByte = ASCII_CR;
      3'd4:    nextByte = ASCII_LF;
`endif
      default: nextByte = wordBuf[23:16];
    endcase
  end

  // First byte comes straight from the input so the start bit begins on the
  // accepting edge; later bytes are fed in the serializer's last stop cycle.
  always_comb begin
    txValid = 1'b0;
    txByte  = bus.asciiNum[23:16];
    if (!busyR) begin
      txValid = bus.ifStart;
    end else if (txReady && !lastByte) begin
      txValid = 1'b1;
      txByte  = nextByte;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      byteIdx <= '0;
      wordBuf <= '0;
    end else begin
      doneR <= 1'b0;
      if (accept) begin
        busyR   <= 1'b1;
        byteIdx <= '0;
        wordBuf <= bus.asciiNum;
      end else if (busyR && txReady) begin
        if (lastByte) begin
          busyR <= 1'b0;
          doneR <= 1'b1;
        end else begin
          byteIdx <= nextIdx;
        end
      end
    end
  end

  assign bus.ifBusy = busyR;
  assign bus.ifDone = doneR;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTxByte (
    .clk    (clk),
    .rstN   (rstN),
    .txByte (txByte),
    .txValid(txValid),
    .txReady(txReady),
    .txd    (bus.txd)
  );

endmodule

// File: tb/tb_ascii_uart_sender.sv
// Self-checking bench for ascii_uart_sender at CLK_FREQ=1 MHz, BAUD=100 kbit/s
// (10 clocks per bit). Honours TX_CRLF_EN for the expected byte count.
module tb_ascii_uart_sender;

  localparam int CF  = 1_000_000;
  localparam int BD  = 100_000;
  localparam int CPB = 10;
`ifdef TX_CRLF_EN
  localparam int NB = 5;
`else
  localparam int NB = 3;
`endif
  localparam int FR = NB * 10 * CPB;

  logic clk = 1'b0;
  logic rstN;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ascii_uart_sender_if busIf ();

  ascii_uart_sender #(
    .CLK_FREQ(CF),
    .BAUD    (BD)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (busIf)
  );

  typedef struct {
    logic [23:0] word;
    logic [23:0] expBytes;
    int          chgAt;
    logic [23:0] chgVal;
    int          pulseAt;
    bit          late;
  } vec_t;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame bit idx: 10 bits per byte (start, 8 data LSB first, stop).
  function automatic logic expBit(input logic [39:0] e, input int idx);
    int b, j;
    logic [7:0] by;
    b = idx / 10;
    j = idx % 10;
    by = e[39-8*b -: 8];
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return by[j-1];
  endfunction

  // Called right after the accepting edge; follows the frame to ifDone.
  task automatic watchFrame(input logic [39:0] e, input int chgAt, input logic [23:0] chgVal,
                            input int pulseAt, input bit late, input bit hold);
    for (int c = 1; c <= FR; c++) begin
      step();
      if (c == chgAt) busIf.asciiNum = chgVal;
      if (c == pulseAt) busIf.ifStart = 1'b1;
      if (c == pulseAt + 1) busIf.ifStart = 1'b0;
      if (late && c == FR - 1) busIf.ifStart = 1'b1;
      if (c < FR) begin
        chk("frame_busy_done", {busIf.ifBusy, busIf.ifDone}, 2'b10);
        if (c % 10 == 5) chk("txd_bit", busIf.txd, expBit(e, c / 10));
      end else begin
        chk("done_edge_busy_done_txd", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b011);
      end
    end
    if (!hold) begin
      busIf.ifStart = 1'b0;
      for (int c = 0; c < 30; c++) begin
        step();
        chk("idle_after_done", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b001);
      end
    end
  endtask

  task automatic sendFrame(input logic [23:0] word, input logic [23:0] expBytes, input int chgAt,
                           input logic [23:0] chgVal, input int pulseAt, input bit late, input bit hold);
    busIf.asciiNum = word;
    busIf.ifStart  = 1'b1;
    step();
    busIf.ifStart = 1'b0;
    chk("accept_busy_txd", {busIf.ifBusy, busIf.txd}, 2'b10);
    watchFrame({expBytes, 16'h0D0A}, chgAt, chgVal, pulseAt, late, hold);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{24'h323535, 24'h323535, -1, 24'h000000, -1, 1'b0};
    vecs[1] = '{24'h303030, 24'h303030, -1, 24'h000000, -1, 1'b0};
    vecs[2] = '{24'h323535, 24'h323535, 20, 24'h313233, -1, 1'b0};
    vecs[3] = '{24'h313238, 24'h313238, -1, 24'h000000, 50, 1'b1};

    rstN           = 1'b0;
    busIf.ifStart  = 1'b0;
    busIf.asciiNum = '0;
    repeat (3) step();
    chk("reset_state", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b001);
    rstN = 1'b1;
    repeat (2) step();
    chk("idle_after_reset", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b001);

    for (int i = 0; i < 4; i++) begin
      sendFrame(vecs[i].word, vecs[i].expBytes, vecs[i].chgAt, vecs[i].chgVal,
                vecs[i].pulseAt, vecs[i].late, 1'b0);
    end

    // ifStart high at the done edge and held one more cycle: second frame starts.
    sendFrame(24'h303432, 24'h303432, -1, 24'h0, -1, 1'b1, 1'b1);
    busIf.asciiNum = 24'h393837;
    step();
    busIf.ifStart = 1'b0;
    chk("held_start_accepted", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b100);
    watchFrame({24'h393837, 16'h0D0A}, -1, 24'h0, -1, 1'b0, 1'b0);

    // Async reset mid-frame.
    busIf.asciiNum = 24'h323535;
    busIf.ifStart  = 1'b1;
    step();
    busIf.ifStart = 1'b0;
    repeat (150) step();
    chk("busy_before_reset", busIf.ifBusy, 1'b1);
    #2 rstN = 1'b0;
    #1 chk("async_reset_outputs", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b001);
    step();
    rstN = 1'b1;
    for (int c = 0; c < FR + 20; c++) begin
      step();
      chk("no_done_after_reset", {busIf.ifBusy, busIf.ifDone, busIf.txd}, 3'b001);
    end
    sendFrame(24'h323535, 24'h323535, -1, 24'h0, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
